// File: rtl/controlador_somador_subtrator_pkg.sv
// Shared types and constants for the add/sub coprocessor sequencer.
// Combinational definitions only. No latency or backpressure.
package pacote_coprocessador;

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        RESULTADO
    } estado_t;

    localparam logic OP_SOMA      = 1'b0;
    localparam logic OP_SUB       = 1'b1;
    localparam int   LARGURA_DADO = 8;

endpackage

// File: rtl/modulo_somador_subtrator.sv
// 8-bit add/sub unit: A + B, or A + ~B + 1. Bit 8 is the carry for soma and the borrow (A<B) for sub.
// Purely combinational, so there is no latency and no backpressure.
module modulo_somador_subtrator
    import pacote_coprocessador::*;
(
    input  logic [LARGURA_DADO-1:0] a,
    input  logic [LARGURA_DADO-1:0] b,
    input  logic                    op,
    output logic [LARGURA_DADO:0]   resultado
);

    logic [LARGURA_DADO-1:0] b_efetivo;
    logic [LARGURA_DADO:0]   soma_bruta;

    always_comb begin
        b_efetivo  = (op == OP_SUB) ? ~b : b;
        soma_bruta = {1'b0, a} + {1'b0, b_efetivo} + {{LARGURA_DADO{1'b0}}, op};
        // For sub, carry out of A + ~B + 1 is set when A >= B, so invert it to get the borrow.
        resultado  = {soma_bruta[LARGURA_DADO] ^ op, soma_bruta[LARGURA_DADO-1:0]};
    end

endmodule

// File: rtl/controlador_somador_subtrator.sv
// Sequencer around modulo_somador_subtrator: accept, compute, then hold the result. `SATURACAO_EN` enables saturation.
// Latency: out_valid rises two cycles after the accept cycle. The unit handles at most one command every 3 cycles.
// Backpressure: while out_ready is low, the result and flags hold and in_ready stays low.
module controlador_somador_subtrator
    import pacote_coprocessador::*;
#(
    parameter int LARGURA_CONT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LARGURA_DADO-1:0] in_a,
    input  logic [LARGURA_DADO-1:0] in_b,
    input  logic                    in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LARGURA_DADO:0]   out_resultado,
    output logic                    out_zero,
    output logic                    out_sat,
    output logic [LARGURA_CONT-1:0] contador_ops
);

    localparam logic [LARGURA_CONT-1:0] UM = LARGURA_CONT'(1);

    estado_t                 estado, proximo;
    logic [LARGURA_DADO-1:0] a_q, b_q;
    logic                    op_q;
    logic [LARGURA_DADO:0]   res_unidade;
    logic [LARGURA_DADO:0]   res_final;
    logic                    sat_final;
    logic                    aceita, entrega;

    modulo_somador_subtrator u_unidade (
        .a         (a_q),
        .b         (b_q),
        .op        (op_q),
        .resultado (res_unidade)
    );

`ifdef SATURACAO_EN
    always_comb begin
        res_final = res_unidade;
        sat_final = 1'b0;
        if (res_unidade[LARGURA_DADO]) begin
            sat_final = 1'b1;
            res_final = (op_q == OP_SOMA) ? 9'h1FF : 9'h100;
        end
    end
`else
    assign res_final = res_unidade;
    assign sat_final = 1'b0;
`endif

    always_comb begin
        proximo   = estado;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (estado)
            OCIOSO: begin
                in_ready = 1'b1;
                if (in_valid) proximo = CALCULA;
            end
            CALCULA: proximo = RESULTADO;
            RESULTADO: begin
                out_valid = 1'b1;
                if (out_ready) proximo = OCIOSO;
            end
            default: proximo = OCIOSO;
        endcase
    end

    assign aceita  = (estado == OCIOSO) && in_valid;
    assign entrega = (estado == RESULTADO) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado        <= OCIOSO;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= OP_SOMA;
            out_resultado <= '0;
            out_zero      <= 1'b0;
            out_sat       <= 1'b0;
            contador_ops  <= '0;
        end else begin
            estado <= proximo;
            if (aceita) begin
                a_q  <= in_a;
                b_q  <= in_b;
                op_q <= in_op;
            end
            if (estado == CALCULA) begin
                out_resultado <= res_final;
                out_zero      <= (res_final[LARGURA_DADO-1:0] == '0);
                out_sat       <= sat_final;
            end
            if (entrega) contador_ops <= contador_ops + UM;
        end
    end

endmodule

// File: tb/tb_controlador_somador_subtrator.sv
// Directed bench for the add/sub sequencer. Expected results are queued when a command is accepted and compared on delivery.
module tb_controlador_somador_subtrator;

    localparam int LC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_a;
    logic [7:0]    in_b;
    logic          in_op;
    logic          out_valid;
    logic          out_ready;
    logic [8:0]    out_resultado;
    logic          out_zero;
    logic          out_sat;
    logic [LC-1:0] contador_ops;

    controlador_somador_subtrator #(.LARGURA_CONT(LC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_op         (in_op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_resultado (out_resultado),
        .out_zero      (out_zero),
        .out_sat       (out_sat),
        .contador_ops  (contador_ops)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] res;
        logic       zero;
        logic       sat;
    } esperado_t;

    esperado_t     fila[$];
    int            checks = 0;
    int            errors = 0;
    logic [LC-1:0] cont_model;

    function automatic esperado_t modelo(input logic [7:0] a, input logic [7:0] b, input logic op);
        esperado_t  e;
        logic [8:0] s;
        if (op == 1'b0) begin
            s = {1'b0, a} + {1'b0, b};
        end else begin
            s[8]   = (a < b);
            s[7:0] = 8'(a - b);
        end
        e.sat = 1'b0;
`ifdef SATURACAO_EN
        if (s[8]) begin
            e.sat = 1'b1;
            s     = (op == 1'b0) ? 9'h1FF : 9'h100;
        end
`endif
        e.res  = s;
        e.zero = (s[7:0] == 8'h00);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic envia(input logic [7:0] a, input logic [7:0] b, input logic op);
        int n;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("timeout_accept", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        fila.push_back(modelo(a, b, op));
        #1 in_valid = 1'b0;
    endtask

    task automatic recebe(input string tag);
        int        n;
        esperado_t e;
        out_ready = 1'b1;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        if (fila.size() == 0) begin
            chk({tag, "_unexpected"}, 32'(fila.size()), 32'd1);
            return;
        end
        e = fila.pop_front();
        chk({tag, "_res"}, 32'(out_resultado), 32'(e.res));
        chk({tag, "_zero"}, 32'(out_zero), 32'(e.zero));
        chk({tag, "_sat"}, 32'(out_sat), 32'(e.sat));
        @(posedge clk);
        cont_model = cont_model + 1'b1;
        #1 chk({tag, "_cnt"}, 32'(contador_ops), 32'(cont_model));
    endtask

    task automatic reinicia();
        @(negedge clk);
        rst_n = 1'b0;
        fila.delete();
        cont_model = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] res_snap;
        logic       zero_snap;
        logic       sat_snap;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_op      = 1'b0;
        out_ready  = 1'b1;
        cont_model = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(out_resultado), 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        chk("rst_cnt", 32'(contador_ops), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Soma 200+100, with latency checked on each edge after accept.
        envia(8'd200, 8'd100, 1'b0);
        chk("lat_calc_valid", 32'(out_valid), 32'd0);
        chk("lat_calc_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 chk("lat_res_valid", 32'(out_valid), 32'd1);
        recebe("soma_200_100");

        envia(8'd5, 8'd10, 1'b1);
        recebe("sub_5_10");
        envia(8'd10, 8'd10, 1'b1);
        recebe("sub_10_10");
        envia(8'd3, 8'd7, 1'b1);
        recebe("sub_3_7");
        envia(8'd255, 8'd1, 1'b0);
        recebe("soma_255_1");
        envia(8'd0, 8'd0, 1'b0);
        recebe("soma_0_0");

        // Stall the consumer and offer a second command during the stall; it must be ignored.
        out_ready = 1'b0;
        envia(8'd7, 8'd9, 1'b0);
        @(posedge clk);
        #1 chk("stall_valid", 32'(out_valid), 32'd1);
        res_snap  = out_resultado;
        zero_snap = out_zero;
        sat_snap  = out_sat;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_a     = 8'd1;
            in_b     = 8'd1;
            in_op    = 1'b1;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("stall_res_hold", 32'(out_resultado), 32'(res_snap));
            chk("stall_flags_hold", 32'({out_zero, out_sat}), 32'({zero_snap, sat_snap}));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid_hold", 32'(out_valid), 32'd1);
            chk("stall_cnt", 32'(contador_ops), 32'(cont_model));
        end
        in_valid = 1'b0;
        recebe("stall_release");
        @(negedge clk);
        chk("stall_idle_ready", 32'(in_ready), 32'd1);
        chk("stall_no_extra", 32'(out_valid), 32'd0);

        // Reset asserted while in CALCULA.
        envia(8'd40, 8'd2, 1'b0);
        rst_n = 1'b0;
        fila.delete();
        cont_model = '0;
        #1;
        chk("rstcalc_valid", 32'(out_valid), 32'd0);
        chk("rstcalc_cnt", 32'(contador_ops), 32'd0);
        chk("rstcalc_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        envia(8'd40, 8'd2, 1'b0);
        recebe("after_rstcalc");

        // Reset asserted while a result is held.
        out_ready = 1'b0;
        envia(8'd9, 8'd3, 1'b1);
        @(posedge clk);
        #1 chk("rstres_valid_before", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        fila.delete();
        cont_model = '0;
        #1;
        chk("rstres_valid", 32'(out_valid), 32'd0);
        chk("rstres_res", 32'(out_resultado), 32'd0);
        chk("rstres_cnt", 32'(contador_ops), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Seventeen commands back to back wrap a 4-bit counter to 1.
        reinicia();
        for (int i = 0; i < 17; i++) begin
            envia(8'(i * 13), 8'(i * 7), 1'(i % 2));
            recebe("wrap");
        end
        chk("wrap_final", 32'(contador_ops), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
